// File: rtl/uart_transceiver.sv
// -----------------------------------------------------------------------------
// uart_transceiver
//
// Full-duplex 8N1 UART with a fixed baud divider derived from parameters.
// The receive and transmit halves are completely independent, so loopback
// of tx into rx works.
//
// Parameters
//   INPUT_CLOCK   clk frequency in Hz
//   BAUD_RATE     line rate in bit/s
//   CLKS_PER_BIT  = INPUT_CLOCK / BAUD_RATE (truncated), must be >= 4
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx            serial input, idle high, asynchronous to clk
//   rx_data[7:0]  last correctly framed received byte (holds between frames)
//   rx_valid      one-cycle pulse when rx_data is updated
//   tx_start      request to send tx_data, only acted on while tx_busy = 0
//   tx_data[7:0]  byte captured on an accepted tx_start
//   tx_busy       high while a transmit frame is in progress
//   tx            registered serial output, idle high
//   rx_state_dbg  current RX FSM state (0 idle, 1 start, 2 data, 3 stop)
//   tx_state_dbg  current TX FSM state (same encoding)
//
// Handshake: tx_start is a request, tx_busy = 0 is the ready. A frame
// starts on every rising edge where tx_start = 1 and tx_busy = 0; requests
// while busy are dropped, not queued. rx_valid is a strobe with no
// back-pressure: the consumer must take rx_data in the cycle it is high.
// -----------------------------------------------------------------------------
module uart_transceiver #(
    parameter int INPUT_CLOCK = 27000000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx,
    output logic [1:0] rx_state_dbg,
    output logic [1:0] tx_state_dbg
);

    localparam int CLKS_PER_BIT = INPUT_CLOCK / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    // Last count of a full bit period and of a half bit period.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // =========================================================================
    // Receive path
    // =========================================================================

    // Two-flop synchronizer; resets to the idle line level so that reset
    // release never looks like a start bit.
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    state_e           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]       rx_bit_q,   rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        unique case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = ST_START;
                end
            end

            // Wait half a bit, then confirm the line is still low. A high
            // line here means the falling edge was a glitch.
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_state_d = ST_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end

            // From the start-bit centre, every full bit period lands on the
            // next bit centre. Bits arrive LSB first, so shift in from the top.
            ST_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end

            // Return to idle straight after the stop-bit centre so that a
            // start bit following immediately can still be caught. A low
            // stop bit is a framing error: the byte is dropped silently.
            ST_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end

            default: begin
                rx_state_d = ST_IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_state_dbg = rx_state_q;

    // =========================================================================
    // Transmit path
    // =========================================================================

    state_e           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
    logic [2:0]       tx_bit_q,   tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q,       tx_d;
    logic             tx_busy_q,  tx_busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // The line value for each bit is set on the same edge the FSM enters
    // that bit, so tx is a plain flop output with no decode glitches.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;

        unique case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d  = '0;
                tx_bit_d  = '0;
                tx_d      = 1'b1;
                tx_busy_d = 1'b0;
                if (tx_start) begin
                    tx_shift_d = tx_data;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = ST_START;
                end
            end

            ST_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end

            // tx_shift_q[0] is always the bit currently on the line.
            ST_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_busy_d  = 1'b0;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end

            default: begin
                tx_state_d = ST_IDLE;
                tx_d       = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    assign tx           = tx_q;
    assign tx_busy      = tx_busy_q;
    assign tx_state_dbg = tx_state_q;

endmodule

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
module tb_uart_transceiver;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Fast instance: 160 Hz / 10 baud -> 16 clocks per bit
  localparam int CPB = 16;

  logic       rx_drv;
  logic       loop_en;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx;
  logic [1:0] rx_state_dbg;
  logic [1:0] tx_state_dbg;

  assign rx = loop_en ? tx : rx_drv;

  uart_transceiver #(.INPUT_CLOCK(160), .BAUD_RATE(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx           (tx),
    .rx_state_dbg (rx_state_dbg),
    .tx_state_dbg (tx_state_dbg)
  );

  // Default-parameter instance, tx looped straight into rx
  logic       d_tx_start;
  logic [7:0] d_tx_data;
  logic       d_tx;
  logic       d_tx_busy;
  logic [7:0] d_rx_data;
  logic       d_rx_valid;
  logic [1:0] d_rx_state_dbg;
  logic [1:0] d_tx_state_dbg;

  uart_transceiver dut_def (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (d_tx),
    .rx_data      (d_rx_data),
    .rx_valid     (d_rx_valid),
    .tx_start     (d_tx_start),
    .tx_data      (d_tx_data),
    .tx_busy      (d_tx_busy),
    .tx           (d_tx),
    .rx_state_dbg (d_rx_state_dbg),
    .tx_state_dbg (d_tx_state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int rd_idx = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int d_valid_cnt = 0;
  logic [7:0] d_last = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      got_q.push_back(rx_data);
      valid_cnt <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (d_rx_valid === 1'b1) begin
      d_valid_cnt <= d_valid_cnt + 1;
      d_last <= d_rx_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model and driver tasks
  // ---------------------------------------------------------------------------

  // Line level of bit slot idx (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse tx_start for one cycle; returns #1 after the accepting edge.
  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  // Called #1 after the accepting edge. Checks every cycle of the frame,
  // then the busy drop. poke_at >= 0 fires a one-cycle tx_start with 8'hFF
  // at that cycle, which must be ignored.
  task automatic check_tx_frame(input logic [7:0] b, input string tag, input int poke_at);
    int bad_tx;
    int bad_busy;
    bad_tx = 0;
    bad_busy = 0;
    for (int c = 0; c < 10*CPB; c++) begin
      if (tx !== frame_bit(b, c / CPB)) bad_tx++;
      if (tx_busy !== 1'b1) bad_busy++;
      if (poke_at >= 0 && c == poke_at) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
      end else if (poke_at >= 0 && c == poke_at + 1) begin
        tx_start = 1'b0;
      end
      tick();
    end
    check({tag, "_wave_bad_cycles"}, bad_tx, 0);
    check({tag, "_busy_low_cycles"}, bad_busy, 0);
    check({tag, "_busy_end"}, tx_busy, 1'b0);
    check({tag, "_tx_end"}, tx, 1'b1);
  endtask

  task automatic wait_tx_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (tx_busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle_in_budget"}, (n < budget), 1'b1);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_v, input realtime bt);
    rx_drv = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      #(bt);
    end
    rx_drv = stop_v;
    #(bt);
    rx_drv = 1'b1;
  endtask

  // Compare everything received since the last drain with exp_q.
  task automatic drain_check(input string tag);
    int n_got;
    n_got = got_q.size() - rd_idx;
    check({tag, "_count"}, n_got, exp_q.size());
    while (exp_q.size() > 0) begin
      if (rd_idx < got_q.size()) begin
        check({tag, "_byte"}, got_q[rd_idx], exp_q[0]);
        rd_idx++;
      end
      void'(exp_q.pop_front());
    end
    rd_idx = got_q.size();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with randomized content
  // ---------------------------------------------------------------------------
  logic [7:0] byte_list[8];
  logic [7:0] rnd_b;
  int fall_cyc;
  int n0;
  int low_cnt;
  int lat;
  int n;

  initial begin
    byte_list[0] = 8'h00; byte_list[1] = 8'hFF;
    byte_list[2] = 8'h31; byte_list[3] = 8'h32; byte_list[4] = 8'h33;
    byte_list[5] = 8'h34; byte_list[6] = 8'h35; byte_list[7] = 8'h36;

    rst_n = 1'b0;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    d_tx_start = 1'b0;
    d_tx_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // TX 8'hA5 with a one-cycle start pulse
    start_tx(8'hA5);
    check_tx_frame(8'hA5, "tx_a5", -1);

    // Random byte while a busy-time 8'hFF request is ignored
    rnd_b = 8'($urandom_range(0, 255));
    tick();
    start_tx(rnd_b);
    check_tx_frame(rnd_b, "tx_ignore_ff", 40 + int'($urandom_range(0, 60)));

    // Back-to-back 8'h31, 8'h36 with tx_start held
    tick();
    tx_data = 8'h31;
    tx_start = 1'b1;
    tick();
    tx_data = 8'h36;
    check_tx_frame(8'h31, "b2b_31", -1);
    tick();
    tx_start = 1'b0;
    check_tx_frame(8'h36, "b2b_36", -1);
    repeat (5) tick();

    // RX 8'h3C: single pulse, data, latency from the falling edge
    @(posedge clk);
    #2;
    fall_cyc = cyc;
    n0 = valid_cnt;
    exp_q.push_back(8'h3C);
    drive_rx_frame(8'h3C, 1'b1, 160.0);
    repeat (20) tick();
    check("rx_3c_pulses", valid_cnt - n0, 1);
    lat = last_valid_cyc - fall_cyc;
    check("rx_3c_latency_in_window", (lat >= 3 + 8 + 144 - 1 && lat <= 3 + 8 + 144 + 1), 1'b1);
    drain_check("rx_3c");
    check("rx_3c_hold", rx_data, 8'h3C);

    // Glitch of 4 cycles: no output, FSM back to idle
    n0 = valid_cnt;
    @(posedge clk);
    #2;
    rx_drv = 1'b0;
    #40;
    rx_drv = 1'b1;
    repeat (40) tick();
    check("glitch_no_valid", valid_cnt - n0, 0);
    check("glitch_rx_idle", rx_state_dbg, 2'd0);

    // Framing error on 8'h55: dropped, rx_data keeps 8'h3C
    drive_rx_frame(8'h55, 1'b0, 160.0);
    repeat (40) tick();
    check("ferr_no_valid", valid_cnt - n0, 0);
    check("ferr_rx_data_kept", rx_data, 8'h3C);
    drain_check("ferr");

    // Bench-driven frames at +2% and -2% bit period, back to back
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(byte_list[k]);
      for (int r = 0; r < 2; r++) exp_q.push_back(8'($urandom_range(0, 255)));
      for (int k = 0; k < 10; k++) drive_rx_frame(exp_q[k], 1'b1, (s == 0) ? 163.2 : 156.8);
      repeat (40) tick();
      drain_check((s == 0) ? "rx_skew_slow" : "rx_skew_fast");
    end

    // Loopback tx -> rx at the nominal rate
    loop_en = 1'b1;
    repeat (5) tick();
    for (int k = 0; k < 10; k++) begin
      rnd_b = (k < 8) ? byte_list[k] : 8'($urandom_range(0, 255));
      wait_tx_idle("loop", 400);
      exp_q.push_back(rnd_b);
      start_tx(rnd_b);
    end
    wait_tx_idle("loop_last", 400);
    repeat (20) tick();
    drain_check("loopback");
    loop_en = 1'b0;
    repeat (5) tick();

    // Asynchronous reset in the middle of a TX frame
    start_tx(8'h00);
    repeat (50) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tx", tx, 1'b1);
    check("arst_tx_busy", tx_busy, 1'b0);
    check("arst_rx_valid", rx_valid, 1'b0);
    check("arst_tx_state", tx_state_dbg, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = valid_cnt;
    low_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) low_cnt++;
    end
    check("post_rst_tx_idle_violations", low_cnt, 0);
    check("post_rst_no_valid", valid_cnt - n0, 0);
    check("post_rst_rx_data", rx_data, 8'h00);

    // Default parameters: 2812 clocks per bit, looped back
    d_tx_data = 8'hA5;
    d_tx_start = 1'b1;
    tick();
    d_tx_start = 1'b0;
    n = 0;
    while (d_tx_busy === 1'b1 && n < 40000) begin
      tick();
      n++;
    end
    check("def_busy_cycles", n, 10 * 2812);
    repeat (10) tick();
    check("def_rx_pulses", d_valid_cnt, 1);
    check("def_rx_data", d_last, 8'hA5);
    check("def_tx_idle", d_tx, 1'b1);
    check("def_tx_state", d_tx_state_dbg, 2'd0);
    check("def_rx_state", d_rx_state_dbg, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
